// File: rtl/pip_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pip_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } pip_state_e;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pip_fwd_unit.sv
// EX-stage operand forwarding select for one source operand.
// Only built when PIP_FORWARDING_EN is defined.
`ifdef PIP_FORWARDING_EN
module pip_fwd_unit
    import pip_ctrl_pkg::*;
(
    input  logic       rs_read_i,
    input  logic [4:0] rs_ad_i,
    input  logic       mem_rdEn_i,
    input  logic [4:0] mem_rd_ad_i,
    input  logic       wb_rdEn_i,
    input  logic [4:0] wb_rd_ad_i,
    output logic [1:0] sel_o
);

    // The younger writer (EX/MEM) wins; x0 always reads as zero.
    always_comb begin
        sel_o = FWD_RF;
        if (rs_read_i && rs_ad_i != REG_X0) begin
            if (mem_rdEn_i && mem_rd_ad_i == rs_ad_i)
                sel_o = FWD_MEM;
            else if (wb_rdEn_i && wb_rd_ad_i == rs_ad_i)
                sel_o = FWD_WB;
        end
    end

endmodule
`endif

// File: rtl/pip_hazard_ctrl.sv
// Pipeline enable/discard sequencing, hazard stalls and EX forwarding selects.
// PIP_FORWARDING_EN selects forwarding (load-use stalls only) vs. full RAW stalling.
module pip_hazard_ctrl
    import pip_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_ad,
    input  logic [4:0]       id_rs2_ad,
    input  logic             id_rs1_read,
    input  logic             id_rs2_read,
    input  logic [4:0]       ex_rs1_ad,
    input  logic [4:0]       ex_rs2_ad,
    input  logic             ex_rs1_read,
    input  logic             ex_rs2_read,
    input  logic [4:0]       ex_rd_ad,
    input  logic             ex_rdEn,
    input  logic             ex_DMread,
    input  logic [4:0]       mem_rd_ad,
    input  logic             mem_rdEn,
    input  logic [4:0]       wb_rd_ad,
    input  logic             wb_rdEn,
    input  logic             br_mispredict,
    input  logic             dm_req,
    input  logic             dm_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_discard,
    output logic             id_ex_discard,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    pip_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_q, stall_d, flush_q, flush_d;
    logic              stall_inc, flush_inc, freeze, hazard;
    logic              ex_hit, mem_hit;
    logic [1:0]        fwd_a, fwd_b;

    assign ex_hit = ex_rdEn && ex_rd_ad != REG_X0 &&
                    ((id_rs1_read && id_rs1_ad == ex_rd_ad) || (id_rs2_read && id_rs2_ad == ex_rd_ad));
    assign mem_hit = mem_rdEn && mem_rd_ad != REG_X0 &&
                     ((id_rs1_read && id_rs1_ad == mem_rd_ad) || (id_rs2_read && id_rs2_ad == mem_rd_ad));

`ifdef PIP_FORWARDING_EN
    assign hazard = ex_hit && ex_DMread;

    pip_fwd_unit u_fwd_a (
        .rs_read_i(ex_rs1_read), .rs_ad_i(ex_rs1_ad),
        .mem_rdEn_i(mem_rdEn), .mem_rd_ad_i(mem_rd_ad),
        .wb_rdEn_i(wb_rdEn), .wb_rd_ad_i(wb_rd_ad),
        .sel_o(fwd_a)
    );
    pip_fwd_unit u_fwd_b (
        .rs_read_i(ex_rs2_read), .rs_ad_i(ex_rs2_ad),
        .mem_rdEn_i(mem_rdEn), .mem_rd_ad_i(mem_rd_ad),
        .wb_rdEn_i(wb_rdEn), .wb_rd_ad_i(wb_rd_ad),
        .sel_o(fwd_b)
    );
`else
    // Register file writes before it reads, so WB never needs a stall here.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ex_rs1_ad, ex_rs2_ad, ex_rs1_read, ex_rs2_read,
                                 ex_DMread, wb_rd_ad, wb_rdEn};
    assign hazard = ex_hit || mem_hit;
    assign fwd_a  = FWD_RF;
    assign fwd_b  = FWD_RF;
`endif

    assign freeze = dm_req && !dm_ack;

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        err_d         = err_q;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_en     = 1'b0;
        if_id_discard = 1'b0;
        id_ex_discard = 1'b0;
        if (rst || state_q == ERR) begin
            // everything frozen
        end else if (freeze) begin
            wait_d  = wait_q + WAIT_W'(1);
            state_d = MEM_WAIT;
            if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                state_d = ERR;
                err_d   = 1'b1;
            end
        end else begin
            state_d   = RUN;
            wait_d    = '0;
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (br_mispredict) begin
                if_id_discard = 1'b1;
                id_ex_discard = 1'b1;
                flush_inc     = 1'b1;
            end else if (hazard) begin
                pc_en         = 1'b0;
                if_id_en      = 1'b0;
                id_ex_discard = 1'b1;
                stall_inc     = 1'b1;
            end
        end
    end

    assign stall_d = (stall_inc && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
    assign flush_d = (flush_inc && flush_q != '1) ? flush_q + CNT_W'(1) : flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign fwd_a_sel = rst ? FWD_RF : fwd_a;
    assign fwd_b_sel = rst ? FWD_RF : fwd_b;
    assign mem_err   = err_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pip_hazard_ctrl.sv
// Directed scoreboard bench for pip_hazard_ctrl (CNT_W=2, MEM_TIMEOUT=4).
module tb_pip_hazard_ctrl;

`ifdef PIP_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_discard, id_ex_discard}
    localparam logic [6:0] FRZ   = 7'b00000_00;
    localparam logic [6:0] NORM  = 7'b11111_00;
    localparam logic [6:0] STALL = 7'b00111_01;
    localparam logic [6:0] FLUSH = 7'b11111_11;

    typedef struct {
        logic [6:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [1:0] stall;
        logic [1:0] flush;
        logic       err;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [4:0] id_rs1_ad, id_rs2_ad, ex_rs1_ad, ex_rs2_ad, ex_rd_ad, mem_rd_ad, wb_rd_ad;
    logic id_rs1_read, id_rs2_read, ex_rs1_read, ex_rs2_read, ex_rdEn, ex_DMread;
    logic mem_rdEn, wb_rdEn, br_mispredict, dm_req, dm_ack;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_discard, id_ex_discard;
    logic [1:0] fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt;
    logic mem_err;

    exp_t sb[$];
    int nchk = 0, npass = 0;
    logic [1:0] exp_stall = 2'd0, exp_flush = 2'd0;

    always #5 clk = ~clk;

    pip_hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_ad(id_rs1_ad), .id_rs2_ad(id_rs2_ad),
        .id_rs1_read(id_rs1_read), .id_rs2_read(id_rs2_read),
        .ex_rs1_ad(ex_rs1_ad), .ex_rs2_ad(ex_rs2_ad),
        .ex_rs1_read(ex_rs1_read), .ex_rs2_read(ex_rs2_read),
        .ex_rd_ad(ex_rd_ad), .ex_rdEn(ex_rdEn), .ex_DMread(ex_DMread),
        .mem_rd_ad(mem_rd_ad), .mem_rdEn(mem_rdEn),
        .wb_rd_ad(wb_rd_ad), .wb_rdEn(wb_rdEn),
        .br_mispredict(br_mispredict), .dm_req(dm_req), .dm_ack(dm_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_discard(if_id_discard), .id_ex_discard(id_ex_discard),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nchk++;
        assert (got === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic clr();
        {id_rs1_ad, id_rs2_ad, ex_rs1_ad, ex_rs2_ad, ex_rd_ad, mem_rd_ad, wb_rd_ad} = '0;
        {id_rs1_read, id_rs2_read, ex_rs1_read, ex_rs2_read, ex_rdEn, ex_DMread} = '0;
        {mem_rdEn, wb_rdEn, br_mispredict, dm_req, dm_ack} = '0;
    endtask

    // One cycle: push expectation, check combinational controls, clock, check registers.
    task automatic step(input string tag, input logic [6:0] ctl, input logic [1:0] fa,
                        input logic [1:0] fb, input bit st, input bit fl, input logic err);
        exp_t e;
        if (st && exp_stall != 2'b11) exp_stall++;
        if (fl && exp_flush != 2'b11) exp_flush++;
        sb.push_back('{ctl, fa, fb, exp_stall, exp_flush, err});
        #2;
        e = sb.pop_front();
        chk({tag, ".ctl"}, {1'b0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                            if_id_discard, id_ex_discard}, {1'b0, e.ctl});
        chk({tag, ".fwd_a"}, {6'd0, fwd_a_sel}, {6'd0, e.fa});
        chk({tag, ".fwd_b"}, {6'd0, fwd_b_sel}, {6'd0, e.fb});
        @(posedge clk);
        #1;
        chk({tag, ".stall_cnt"}, {6'd0, stall_cnt}, {6'd0, e.stall});
        chk({tag, ".flush_cnt"}, {6'd0, flush_cnt}, {6'd0, e.flush});
        chk({tag, ".mem_err"}, {7'd0, mem_err}, {7'd0, e.err});
    endtask

    task automatic load_use();
        clr();
        ex_DMread = 1; ex_rdEn = 1; ex_rd_ad = 5; id_rs1_ad = 5; id_rs1_read = 1;
    endtask

    initial begin
        clr();
        // Reset holds outputs low even with a forwardable operand present.
        mem_rdEn = 1; mem_rd_ad = 7; ex_rs2_ad = 7; ex_rs2_read = 1;
        step("reset", FRZ, 0, 0, 0, 0, 0);
        rst = 1'b0;
        clr();
        step("idle", NORM, 0, 0, 0, 0, 0);

        load_use();
        step("load_use", STALL, 0, 0, 1, 0, 0);
        clr();
        mem_rdEn = 1; mem_rd_ad = 5; ex_rs1_ad = 5; ex_rs1_read = 1; ex_rdEn = 1; ex_rd_ad = 6;
        step("after_bubble", NORM, FWD ? 2'd1 : 2'd0, 0, 0, 0, 0);

        load_use(); br_mispredict = 1;
        step("mispredict", FLUSH, 0, 0, 0, 1, 0);

        clr();
        mem_rdEn = 1; wb_rdEn = 1; mem_rd_ad = 7; wb_rd_ad = 7; ex_rs2_ad = 7; ex_rs2_read = 1;
        step("fwd_prio", NORM, 0, FWD ? 2'd1 : 2'd0, 0, 0, 0);
        mem_rdEn = 0;
        step("fwd_wb", NORM, 0, FWD ? 2'd2 : 2'd0, 0, 0, 0);
        mem_rdEn = 1; mem_rd_ad = 0; wb_rd_ad = 0; ex_rs2_ad = 0;
        step("fwd_x0", NORM, 0, 0, 0, 0, 0);
        clr();
        wb_rdEn = 1; wb_rd_ad = 9; ex_rs1_ad = 9;
        step("fwd_unread", NORM, 0, 0, 0, 0, 0);
        ex_rs1_read = 1;
        step("fwd_a_wb", NORM, FWD ? 2'd2 : 2'd0, 0, 0, 0, 0);

        clr();
        ex_rdEn = 1; ex_rd_ad = 3; id_rs2_ad = 3; id_rs2_read = 1;
        step("raw_ex", FWD ? NORM : STALL, 0, 0, !FWD, 0, 0);
        clr();
        mem_rdEn = 1; mem_rd_ad = 4; id_rs1_ad = 4; id_rs1_read = 1;
        step("raw_mem", FWD ? NORM : STALL, 0, 0, !FWD, 0, 0);
        clr();
        wb_rdEn = 1; wb_rd_ad = 4; id_rs1_ad = 4; id_rs1_read = 1;
        step("raw_wb", NORM, 0, 0, 0, 0, 0);

        // Memory wait with a mispredict held across the freeze.
        clr();
        dm_req = 1; br_mispredict = 1;
        for (int i = 0; i < 3; i++) step("mem_wait", FRZ, 0, 0, 0, 0, 0);
        dm_ack = 1;
        step("mem_ack", FLUSH, 0, 0, 0, 1, 0);
        br_mispredict = 0;
        step("req_ack_same", NORM, 0, 0, 0, 0, 0);

        // Counter saturation at 2'b11.
        for (int i = 0; i < 5; i++) begin
            load_use();
            step("stall_sat", STALL, 0, 0, 1, 0, 0);
        end
        clr(); br_mispredict = 1;
        for (int i = 0; i < 2; i++) step("flush_sat", FLUSH, 0, 0, 0, 1, 0);

        // Timeout into ERR, which ignores everything until reset.
        clr(); dm_req = 1;
        for (int i = 0; i < 3; i++) step("timeout_wait", FRZ, 0, 0, 0, 0, 0);
        step("timeout_hit", FRZ, 0, 0, 0, 0, 1);
        clr(); br_mispredict = 1;
        step("err_hold", FRZ, 0, 0, 0, 0, 1);
        load_use();
        step("err_hold2", FRZ, 0, 0, 0, 0, 1);

        // Asynchronous reset clears registers before any clock edge.
        rst = 1'b1;
        #1;
        chk("async_rst.stall_cnt", {6'd0, stall_cnt}, 8'd0);
        chk("async_rst.flush_cnt", {6'd0, flush_cnt}, 8'd0);
        chk("async_rst.mem_err", {7'd0, mem_err}, 8'd0);
        exp_stall = 0; exp_flush = 0;
        clr();
        step("rst_hold", FRZ, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step("post_rst", NORM, 0, 0, 0, 0, 0);

        // Reset out of MEM_WAIT returns to RUN.
        dm_req = 1;
        step("wait_pre_rst", FRZ, 0, 0, 0, 0, 0);
        rst = 1'b1;
        clr();
        step("wait_rst", FRZ, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step("wait_post_rst", NORM, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
